// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: pulls bursts of BURST words from a first-word-fall-through
// FIFO and presents them on a valid/ready stream, marking the final word of each
// burst with m_last and pulsing burst_done when that word is accepted.
// Optional feature: define FIFO_BURST_READER_TIMEOUT_EN to flush a partial
// burst after TOUT idle cycles; without it only full bursts are issued.
module fifo_burst_reader #(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 4,
  parameter int BURST  = 4,
  parameter int TOUT   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_empty,
  input  logic [AWIDTH:0]   fifo_level,
  input  logic [DWIDTH-1:0] fifo_dout,
  output logic              fifo_rden,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DWIDTH-1:0] m_data,
  output logic              m_last,
  output logic              busy,
  output logic              burst_done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [AWIDTH:0] BURST_L = (AWIDTH + 1)'(BURST);
  localparam logic [AWIDTH:0] REM_ONE = (AWIDTH + 1)'(1);

  state_t            state_q, state_d;
  logic [AWIDTH:0]   rem_q;
  logic              load_full;
  logic              load_part;

`ifdef FIFO_BURST_READER_TIMEOUT_EN
  localparam int            TW        = (TOUT > 1) ? $clog2(TOUT) : 1;
  localparam logic [TW-1:0] TOUT_LAST = TW'(TOUT - 1);

  logic [TW-1:0] timer_q;
  logic          in_partial;

  assign in_partial = (fifo_level != '0) && (fifo_level < BURST_L);
`endif

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous, and all sequential state uses non-blocking
    // assignments so every flop samples pre-edge values.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state, burst load decisions, pop strobe and completion pulse.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // through the case statement can infer a latch.
    state_d    = state_q;
    load_full  = 1'b0;
    load_part  = 1'b0;
    fifo_rden  = 1'b0;
    burst_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (fifo_level >= BURST_L) begin
          load_full = 1'b1;
          state_d   = XFER;
        end
`ifdef FIFO_BURST_READER_TIMEOUT_EN
        else if (in_partial && (timer_q == TOUT_LAST)) begin
          load_part = 1'b1;
          state_d   = XFER;
        end
`endif
      end
      XFER: begin
        fifo_rden = (rem_q != '0) && !fifo_empty && (!m_valid || m_ready);
        // The pop of the final word moves us on; that word is still held.
        if (fifo_rden && (rem_q == REM_ONE)) state_d = DRAIN;
      end
      DRAIN: begin
        if (m_valid && m_ready && m_last) begin
          burst_done = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Combinational strobes must be quiet during the reset cycle itself.
    if (rst) begin
      fifo_rden  = 1'b0;
      burst_done = 1'b0;
    end
  end

  // Words remaining in the current burst; level changes mid-burst are ignored.
  always_ff @(posedge clk) begin
    if (rst)            rem_q <= '0;
    else if (load_full) rem_q <= BURST_L;
    else if (load_part) rem_q <= fifo_level;
    else if (fifo_rden) rem_q <= rem_q - REM_ONE;
  end

`ifdef FIFO_BURST_READER_TIMEOUT_EN
  // Idle timer: counts IDLE cycles spent holding a partial burst.
  always_ff @(posedge clk) begin
    if (rst)
      timer_q <= '0;
    else if ((state_q == IDLE) && in_partial && !load_part)
      timer_q <= timer_q + TW'(1);
    else
      timer_q <= '0;
  end
`endif

  // Output word register: load on pop, clear on acceptance, hold while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_last  <= 1'b0;
      m_data  <= '0;
    end else if (fifo_rden) begin
      m_valid <= 1'b1;
      m_last  <= (rem_q == REM_ONE);
      m_data  <= fifo_dout;
    end else if (m_valid && m_ready) begin
      m_valid <= 1'b0;
      m_last  <= 1'b0;
    end
  end

  assign busy = (state_q != IDLE) && !rst;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb_fifo_burst_reader: self-checking bench for fifo_burst_reader.
// The FIFO is a queue owned by the bench; the expected output stream is a
// queue of {word, last} entries built from the burst-grouping rules.
module tb_fifo_burst_reader;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int BURST = 4;
  localparam int TOUT = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          fifo_empty;
  logic [AW:0]   fifo_level;
  logic [DW-1:0] fifo_dout;
  logic          fifo_rden;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          busy;
  logic          burst_done;

  fifo_burst_reader #(.DWIDTH(DW), .AWIDTH(AW), .BURST(BURST), .TOUT(TOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_level (fifo_level),
    .fifo_dout  (fifo_dout),
    .fifo_rden  (fifo_rden),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last),
    .busy       (busy),
    .burst_done (burst_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  logic [DW-1:0] fifo_q[$];
  exp_t          exp_q[$];
  int            bd_cycles[$];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int bd_count = 0;
  int rden_count = 0;
  int first_rden = -1;
  int n_acc = 0;
  int rdy_mode = 0;
  int rdy_pct = 100;
  int phase = 0;

  logic          prev_rden = 1'b0;
  logic [DW-1:0] prev_word = '0;
  logic          prev_hold = 1'b0;
  logic [DW-1:0] hold_md = '0;
  logic          hold_ml = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic drive_fifo();
    fifo_empty = (fifo_q.size() == 0);
    fifo_level = (AW + 1)'(fifo_q.size());
    fifo_dout  = (fifo_q.size() == 0) ? '0 : fifo_q[0];
  endtask

  function automatic logic next_rdy();
    case (rdy_mode)
      0:       return 1'b1;
      1:       return (phase % 3) == 0;
      default: return $urandom_range(0, 99) < rdy_pct;
    endcase
  endfunction

  // One clock cycle: drive ready, sample settled outputs, check, then pop the
  // bench FIFO if the DUT strobed it at the edge.
  task automatic tick();
    logic          s_rden, s_mv, s_ml, s_bd, s_empty;
    logic [DW-1:0] s_md, s_head;
    exp_t          e;
    m_ready = next_rdy();
    phase++;
    #1;
    s_rden = fifo_rden; s_mv = m_valid; s_ml = m_last; s_md = m_data;
    s_bd = burst_done; s_empty = fifo_empty; s_head = fifo_dout;
    if (rst) begin
      check("rst_rden", s_rden, 0);
      check("rst_burst_done", s_bd, 0);
      prev_rden = 1'b0;
      prev_hold = 1'b0;
    end else begin
      if (prev_rden) begin
        check("pop_lat_valid", s_mv, 1);
        check("pop_lat_data", s_md, prev_word);
      end
      if (prev_hold) begin
        check("hold_valid", s_mv, 1);
        check("hold_data", s_md, hold_md);
        check("hold_last", s_ml, hold_ml);
      end
      if (s_rden) begin
        check("rden_nonempty", s_empty, 0);
        check("rden_no_stall", s_mv && !m_ready, 0);
        rden_count++;
        if (first_rden < 0) first_rden = cyc;
      end
      check("burst_done", s_bd, s_mv && m_ready && s_ml);
      if (s_mv && m_ready) begin
        check("word_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("data", s_md, e.data);
          check("last", s_ml, e.last);
        end
        n_acc++;
      end
      if (s_bd) begin
        bd_count++;
        bd_cycles.push_back(cyc);
      end
      prev_hold = s_mv && !m_ready;
      hold_md   = s_md;
      hold_ml   = s_ml;
      prev_rden = s_rden;
      prev_word = s_head;
    end
    @(posedge clk);
    if (s_rden && !rst && fifo_q.size() != 0) void'(fifo_q.pop_front());
    cyc++;
    #1;
    drive_fifo();
  endtask

  // Preload words and append their expected stream entries, grouped in BURSTs.
  task automatic preload(input int n, input logic [DW-1:0] base, input bit rnd);
    logic [DW-1:0] w;
    exp_t          e;
    for (int i = 0; i < n; i++) begin
      w = rnd ? DW'($urandom) : base + DW'(i);
      fifo_q.push_back(w);
      e.data = w;
      e.last = (i % BURST) == (BURST - 1);
      exp_q.push_back(e);
    end
    drive_fifo();
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < budget) begin
      tick();
      n++;
    end
    check(tag, n < budget, 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int   c0;
    int   bd0;
    exp_t e;
    m_ready = 1'b1;
    drive_fifo();

    // Reset state.
    tick();
    tick();
    check("rst_m_valid", m_valid, 0);
    check("rst_m_last", m_last, 0);
    check("rst_m_data", m_data, 0);
    check("rst_busy", busy, 0);
    check("rst_fifo_rden", fifo_rden, 0);
    rst = 1'b0;

    // Two back-to-back full bursts with the sink always ready.
    rdy_mode = 0;
    bd_cycles.delete();
    preload(8, 8'h11, 1'b0);
    c0 = cyc;
    tick();
    check("busy_xfer", busy, 1);
    drain("drain_two_bursts", 100);
    check("two_burst_done", bd_cycles.size(), 2);
    if (bd_cycles.size() == 2) begin
      check("burst1_done_cycle", bd_cycles[0] - c0, 5);
      check("burst2_done_cycle", bd_cycles[1] - c0, 11);
    end

    // Partial burst of two words: flushed after TOUT idle cycles, or never.
    first_rden = -1;
    rden_count = 0;
    fifo_q.push_back(8'hA0);
    fifo_q.push_back(8'hA1);
    drive_fifo();
`ifdef FIFO_BURST_READER_TIMEOUT_EN
    e.data = 8'hA0; e.last = 1'b0; exp_q.push_back(e);
    e.data = 8'hA1; e.last = 1'b1; exp_q.push_back(e);
`endif
    c0  = cyc;
    bd0 = bd_count;
    for (int i = 0; i < 40; i++) tick();
`ifdef FIFO_BURST_READER_TIMEOUT_EN
    check("tout_first_pop", first_rden - c0, TOUT);
    drain("drain_partial", 50);
    check("tout_burst_done", bd_count - bd0, 1);
`else
    check("no_tout_rden", rden_count, 0);
    check("no_tout_busy", busy, 0);
    check("no_tout_level", fifo_level, 2);
`endif
    do_reset();
    fifo_q.delete();
    exp_q.delete();
    drive_fifo();

    // Ready toggling 1,0,0: held data while stalled, no pops under backpressure.
    rdy_mode = 1;
    phase = 0;
    preload(4, 8'h61, 1'b0);
    drain("drain_toggle", 100);

    // FIFO emptied externally mid-burst, then refilled.
    rdy_mode = 0;
    fifo_q = '{8'h31, 8'h32, 8'h33, 8'h34};
    e.data = 8'h31; e.last = 1'b0; exp_q.push_back(e);
    e.data = 8'h32; e.last = 1'b0; exp_q.push_back(e);
    drive_fifo();
    for (int i = 0; i < 20 && fifo_q.size() > 2; i++) tick();
    check("steal_point", fifo_q.size(), 2);
    fifo_q.delete();
    drive_fifo();
    rden_count = 0;
    for (int i = 0; i < 3; i++) tick();
    check("stall_no_rden", rden_count, 0);
    check("stall_busy", busy, 1);
    fifo_q.push_back(8'h35);
    fifo_q.push_back(8'h36);
    e.data = 8'h35; e.last = 1'b0; exp_q.push_back(e);
    e.data = 8'h36; e.last = 1'b1; exp_q.push_back(e);
    drive_fifo();
    drain("drain_refill", 50);

    // Reset after two words of a burst; the held word is dropped.
    preload(4, 8'h51, 1'b0);
    n_acc = 0;
    for (int i = 0; i < 20 && n_acc < 2; i++) tick();
    check("two_delivered", n_acc, 2);
    bd0 = bd_count;
    do_reset();
    check("mid_rst_m_valid", m_valid, 0);
    check("mid_rst_m_last", m_last, 0);
    check("mid_rst_m_data", m_data, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_rden", fifo_rden, 0);
    check("mid_rst_left", fifo_q.size(), 1);
    exp_q.delete();
    if (fifo_q.size() != 0) begin
      e.data = fifo_q[0]; e.last = 1'b0; exp_q.push_back(e);
    end
    for (int i = 0; i < 3; i++) begin
      fifo_q.push_back(8'h55 + 8'(i));
      e.data = 8'h55 + 8'(i);
      e.last = (i == 2);
      exp_q.push_back(e);
    end
    drive_fifo();
    drain("drain_after_rst", 50);
    check("after_rst_done", bd_count - bd0, 1);

    // Randomized full bursts with random backpressure.
    rdy_mode = 2;
    for (int r = 0; r < 8; r++) begin
      rdy_pct = $urandom_range(30, 100);
      preload(BURST * $urandom_range(1, 4), '0, 1'b1);
      drain("drain_random", 600);
    end
    check("fifo_empty_end", fifo_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
